// File: rtl/ps2_rx_if.sv
// ps2_rx_if: PS/2 pad inputs and decoded byte/strobe outputs (master = pad/host side, slave = ps2_rx)
interface ps2_rx_if;
  logic kbclk;
  logic in;
  logic [7:0] data;
  logic valid;
  logic parity_err;
  logic frame_err;
  logic busy;
  modport master(output kbclk, in, input data, valid, parity_err, frame_err, busy);
  modport slave(input kbclk, in, output data, valid, parity_err, frame_err, busy);
endinterface

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 frame receiver; ports clk, rst (sync, active-high), bus (kbclk/in from pad; data, valid, parity_err, frame_err, busy out)
module ps2_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT = 50000
) (
  input logic clk,
  input logic rst,
  ps2_rx_if.slave bus
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state;
  logic [1:0] ks, is;
  logic fclk;
  logic [FW-1:0] fcnt;
  logic [TW-1:0] tcnt;
  logic [2:0] bcnt;
  logic [7:0] sh, data_r;
  logic par, valid_r, perr_r, ferr_r;
  logic differ, toggle, fall, tmo, in_s;
  always_comb begin
    in_s = is[1];
    differ = ks[1] != fclk;
    toggle = differ && fcnt == FW'(FILTER_LEN - 1);
    fall = toggle && fclk;
    tmo = state != IDLE && tcnt == TW'(TIMEOUT - 1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ks <= 2'b11;
      is <= 2'b11;
      fclk <= 1'b1;
      fcnt <= '0;
      tcnt <= '0;
      state <= IDLE;
      bcnt <= '0;
      sh <= '0;
      par <= 1'b0;
      data_r <= '0;
      valid_r <= 1'b0;
      perr_r <= 1'b0;
      ferr_r <= 1'b0;
    end else begin
      ks <= {ks[0], bus.kbclk};
      is <= {is[0], bus.in};
      fcnt <= (toggle || !differ) ? '0 : fcnt + 1'b1;
      if (toggle) fclk <= ~fclk;
      valid_r <= 1'b0;
      perr_r <= 1'b0;
      ferr_r <= 1'b0;
      tcnt <= (fall || state == IDLE) ? '0 : (&tcnt ? tcnt : tcnt + 1'b1);
      if (fall) begin
        case (state)
          IDLE: if (!in_s) begin
            state <= DATA;
            bcnt <= '0;
          end
          DATA: begin
            sh <= {in_s, sh[7:1]};
            bcnt <= bcnt + 1'b1;
            if (bcnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par <= in_s;
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            // stop-bit error outranks parity; odd parity over data+parity is good
            if (!in_s) ferr_r <= 1'b1;
            else if (!(^{sh, par})) perr_r <= 1'b1;
            else begin
              data_r <= sh;
              valid_r <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (tmo) begin
        ferr_r <= 1'b1;
        state <= IDLE;
        sh <= '0;
        bcnt <= '0;
      end
    end
  end
  assign bus.data = data_r;
  assign bus.valid = valid_r;
  assign bus.parity_err = perr_r;
  assign bus.frame_err = ferr_r;
  assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: scoreboard bench for ps2_rx with directed PS/2 frames
module tb_ps2_rx;
  localparam int FL = 4;
  localparam int TO = 200;
  localparam int H = 20;
  typedef struct packed {
    logic [2:0] k;
    logic [7:0] d;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int passed = 0;
  int total = 0;
  exp_t q[$];
  ps2_rx_if bus();
  ps2_rx #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", n, got, exp);
    else passed++;
  endtask
  always @(negedge clk) begin
    if (bus.valid || bus.parity_err || bus.frame_err) begin
      total++;
      if (q.size() == 0) begin
        $display("FAIL strobe_unexpected got=%b data=%h", {bus.valid, bus.parity_err, bus.frame_err}, bus.data);
      end else begin
        exp_t e;
        e = q.pop_front();
        if ({bus.valid, bus.parity_err, bus.frame_err} !== e.k || bus.data !== e.d || bus.busy !== 1'b0)
          $display("FAIL strobe got=%b data=%h busy=%b exp=%b data=%h busy=0",
                   {bus.valid, bus.parity_err, bus.frame_err}, bus.data, bus.busy, e.k, e.d);
        else passed++;
      end
    end
  end
  task automatic send_bits(input logic [10:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 bus.in = b[i];
      repeat (H) @(posedge clk);
      #1 bus.kbclk = 1'b0;
      repeat (H) @(posedge clk);
      #1 bus.kbclk = 1'b1;
    end
  endtask
  task automatic frame(input logic [7:0] d, input logic p, input logic s);
    send_bits({s, p, d, 1'b0}, 11);
  endtask
  task automatic chk_reset(input string n);
    chk({n, "_data"}, bus.data, 8'h00);
    chk({n, "_valid"}, bus.valid, 0);
    chk({n, "_perr"}, bus.parity_err, 0);
    chk({n, "_ferr"}, bus.frame_err, 0);
    chk({n, "_busy"}, bus.busy, 0);
  endtask
  initial begin
    int n;
    logic got, anyb;
    logic [10:0] b;
    bus.kbclk = 1'b1;
    bus.in = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    chk_reset("reset");
    q.push_back('{3'b100, 8'h1C});
    frame(8'h1C, 1'b0, 1'b1);
    q.push_back('{3'b010, 8'h1C});
    frame(8'h1C, 1'b1, 1'b1);
    q.push_back('{3'b001, 8'h1C});
    frame(8'hF0, 1'b1, 1'b0);
    repeat (H) @(posedge clk);
    #1 bus.in = 1'b0;
    bus.kbclk = 1'b0;
    repeat (FL - 1) @(posedge clk);
    #1 bus.kbclk = 1'b1;
    anyb = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1 anyb = anyb | bus.busy;
    end
    chk("glitch_busy", anyb, 0);
    bus.in = 1'b1;
    repeat (H) @(posedge clk);
    b = {2'b11, 1'b0, 8'hAA, 1'b0};
    q.push_back('{3'b001, 8'h1C});
    send_bits(b, 5);
    chk("partial_busy", bus.busy, 1);
    @(posedge clk); #1 bus.in = b[5];
    repeat (H) @(posedge clk);
    #1 bus.kbclk = 1'b0;
    n = 0;
    got = 1'b0;
    while (!got && n < 3 * TO) begin
      @(posedge clk); #1 n++;
      if (n == H) bus.kbclk = 1'b1;
      if (bus.frame_err) got = 1'b1;
    end
    chk("timeout_latency", n, FL + 2 + TO);
    repeat (H) @(posedge clk);
    q.push_back('{3'b100, 8'h1C});
    frame(8'h1C, 1'b0, 1'b1);
    q.push_back('{3'b100, 8'hF0});
    q.push_back('{3'b100, 8'h1C});
    frame(8'hF0, 1'b1, 1'b1);
    frame(8'h1C, 1'b0, 1'b1);
    send_bits({2'b11, 8'h55, 1'b0}, 4);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk_reset("midframe_reset");
    repeat (100) @(posedge clk);
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ps2_rx.md
PS2_RX -- requirements
Module: ps2_rx

Interface
Parameters:
REQ-001 SHALL have parameter FILTER_LEN, default 8, giving the consecutive equal kbclk samples needed to accept a level change.
REQ-002 SHALL have parameter TIMEOUT, default 50000, giving the clk cycles without a kbclk falling edge that abort a partial frame.

Ports:
REQ-003 SHALL have port clk  input  1  system clock; one clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port kbclk  input  1  raw PS/2 clock from pad, asynchronous.
REQ-006 SHALL have port in  input  1  raw PS/2 data from pad, asynchronous.
REQ-007 SHALL have port data  output  8  last good scan-code byte, held until next valid.
REQ-008 SHALL have port valid  output  1  one-cycle strobe, data updated this cycle.
REQ-009 SHALL have port parity_err  output  1  one-cycle strobe, frame dropped on odd-parity failure.
REQ-010 SHALL have port frame_err  output  1  one-cycle strobe, frame dropped on bad stop bit or timeout.
REQ-011 SHALL have port busy  output  1  high while the FSM is not in IDLE.

Function
REQ-012 SHALL pass kbclk and in each through a 2-FF synchronizer; both stages reset to 1.
REQ-013 SHALL toggle the filtered clock only after FILTER_LEN consecutive synchronized samples differ from its current value; shorter glitches are ignored.
REQ-014 SHALL generate a one-cycle fall event on a 1->0 change of the filtered clock, and sample synchronized in in that same cycle.
REQ-015 SHALL implement FSM states IDLE, DATA, PARITY, STOP.
REQ-016 IDLE: fall with in=0 -> DATA with bit count 0; fall with in=1 -> stay IDLE, no output.
REQ-017 DATA: each fall shifts in LSB first; after the 8th bit -> PARITY.
REQ-018 PARITY: fall captures the parity bit -> STOP.
REQ-019 STOP: fall -> IDLE, and exactly one of the following strobes SHALL fire.
REQ-020 Stop bit 0 SHALL raise frame_err, with precedence over a parity failure.
REQ-021 Otherwise, an even count of ones over the 8 data bits plus the parity bit SHALL raise parity_err.
REQ-022 Otherwise, the block SHALL load data and raise valid.
REQ-023 SHALL assert valid, parity_err and frame_err in the cycle after the stop-bit fall event, each high for exactly one cycle.
REQ-024 SHALL assert at most one strobe per frame.
REQ-025 A failed frame SHALL leave data unchanged.
REQ-026 SHALL clear the timeout counter on every fall event and in IDLE, and increment it saturating otherwise.
REQ-027 When the timeout counter reaches TIMEOUT-1 outside IDLE, SHALL pulse frame_err, discard the shift register and return to IDLE.
REQ-028 If a fall event and the timeout terminal count occur in the same cycle, the fall event SHALL win and the counter SHALL clear.
REQ-029 SHALL accept back-to-back frames with no minimum idle gap beyond the stop bit.
REQ-030 SHALL have no dependency of receive behaviour on data values; 0xF0 and 0xE0 prefixes pass through as ordinary bytes.

Reset
REQ-031 On rst=1 at a clk edge, SHALL set data=0x00, valid=0, parity_err=0, frame_err=0, busy=0, FSM=IDLE, bit count=0, timeout counter=0.
REQ-032 On rst=1, SHALL set the synchronizers and filtered clock to 1 and the filter counter to 0.
REQ-033 Reset mid-frame SHALL discard the partial frame with no strobe.
REQ-034 The first fall event after rst falls SHALL be treated as a possible start bit.

Verification
REQ-035 Frame 0x1C, parity 0, stop 1 -> valid pulse once; data=0x1C; no error strobes.
REQ-036 Frame 0x1C, parity 1, stop 1 -> parity_err pulse once; valid=0; data keeps its prior value.
REQ-037 Frame 0xF0, parity 1, stop 0 -> frame_err pulse only; busy drops in the same cycle.
REQ-038 FILTER_LEN-1 cycle low glitch on kbclk while IDLE with in=0 -> busy stays 0; no strobes.
REQ-039 Start plus 5 data bits then kbclk held high -> frame_err exactly TIMEOUT cycles after the last fall; the next full 0x1C frame -> valid with data=0x1C.
REQ-040 Back-to-back frames 0xF0 then 0x1C -> two valid pulses, data=0xF0 then 0x1C; rst pulsed after the 3rd bit of a third frame -> no strobe; outputs equal reset values.
